addr_switch: RTL and testbench

Single-input, two-output packet router. A valid transaction (address plus data) is steered to output port A when its address falls in the low address window, and to port B otherwise. Outputs are registered. The block sits between a single transaction source and two downstream consumers that each own half of the address map.

---
 rtl/addr_switch.sv | 84 ++++++++
 tb/tb_addr_switch.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/addr_switch.sv
// addr_switch: single-input, two-output transaction router.
//
// A valid transaction (addr + data) is steered to port A when addr <= ADDR_DIV
// (unsigned, inclusive), otherwise to port B. Both ports are registered and are
// fully rewritten on every accepted transaction: the unselected port is zeroed.
// With vld low, both ports hold their previous values. Latency is one cycle,
// there is no backpressure, and no input reaches an output combinationally.
//
// Ports:
//   clk     in   system clock, all state updates on the rising edge
//   rstn    in   synchronous active-low reset, clears all outputs, overrides vld
//   vld     in   input transaction valid qualifier
//   addr    in   [ADDR_WIDTH-1:0] input address (unsigned)
//   data    in   [DATA_WIDTH-1:0] input payload
//   addr_a  out  [ADDR_WIDTH-1:0] registered address, port A (low window)
//   data_a  out  [DATA_WIDTH-1:0] registered payload, port A
//   addr_b  out  [ADDR_WIDTH-1:0] registered address, port B (high window)
//   data_b  out  [DATA_WIDTH-1:0] registered payload, port B
module addr_switch #(
  parameter int unsigned             ADDR_WIDTH = 8,
  parameter int unsigned             DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]   ADDR_DIV   = 8'h3F
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  vld,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b
);

  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic                  sel_a;

  assign sel_a = (addr <= ADDR_DIV);

  always_comb begin
    // Hold by default; addr/data are only looked at when vld is high so that
    // undefined inputs on idle cycles cannot disturb the outputs.
    addr_a_d = addr_a_q;
    data_a_d = data_a_q;
    addr_b_d = addr_b_q;
    data_b_d = data_b_q;
    if (vld) begin
      if (sel_a) begin
        addr_a_d = addr;
        data_a_d = data;
        addr_b_d = '0;
        data_b_d = '0;
      end else begin
        addr_a_d = '0;
        data_a_d = '0;
        addr_b_d = addr;
        data_b_d = data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_a_q <= '0;
      data_a_q <= '0;
      addr_b_q <= '0;
      data_b_q <= '0;
    end else begin
      addr_a_q <= addr_a_d;
      data_a_q <= data_a_d;
      addr_b_q <= addr_b_d;
      data_b_q <= data_b_d;
    end
  end

  assign addr_a = addr_a_q;
  assign data_a = data_a_q;
  assign addr_b = addr_b_q;
  assign data_b = data_b_q;

endmodule

// File: tb/tb_addr_switch.sv
// Scoreboard bench for addr_switch: stimulus pushes the expected port values
// for each edge into a queue, a separate monitor pops and compares after the edge.
module tb_addr_switch;

  logic        clk;
  logic        rstn;
  logic        vld;
  logic [7:0]  addr;
  logic [15:0] data;
  logic [7:0]  addr_a;
  logic [15:0] data_a;
  logic [7:0]  addr_b;
  logic [15:0] data_b;

  addr_switch #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(16),
    .ADDR_DIV  (8'h3F)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .vld   (vld),
    .addr  (addr),
    .data  (data),
    .addr_a(addr_a),
    .data_a(data_a),
    .addr_b(addr_b),
    .data_b(data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [7:0]  aa;
    logic [15:0] da;
    logic [7:0]  ab;
    logic [15:0] db;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   vec_id;

  // Expected state, used to predict the random stream.
  logic [7:0]  m_aa, m_ab;
  logic [15:0] m_da, m_db;

  task automatic chk(input int id, input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got %h, expected %h", id, nm, act, req);
    end
  endtask

  // Monitor: one expected entry is consumed per edge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.id, "addr_a", {8'h00, addr_a}, {8'h00, e.aa});
        chk(e.id, "data_a", data_a, e.da);
        chk(e.id, "addr_b", {8'h00, addr_b}, {8'h00, e.ab});
        chk(e.id, "data_b", data_b, e.db);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge with explicit expected outputs.
  task automatic step(input logic r, input logic v, input logic [7:0] a,
                      input logic [15:0] d, input logic [7:0] eaa, input logic [15:0] eda,
                      input logic [7:0] eab, input logic [15:0] edb);
    exp_t e;
    @(negedge clk);
    rstn = r;
    vld  = v;
    addr = a;
    data = d;
    e.id = vec_id;
    e.aa = eaa;
    e.da = eda;
    e.ab = eab;
    e.db = edb;
    exp_q.push_back(e);
    m_aa = eaa;
    m_da = eda;
    m_ab = eab;
    m_db = edb;
    vec_id++;
  endtask

  initial begin
    logic        r, v;
    logic [7:0]  a;
    logic [15:0] d;
    checks = 0;
    errors = 0;
    vec_id = 0;
    rstn = 1'b0;
    vld  = 1'b0;
    addr = '0;
    data = '0;
    m_aa = '0;
    m_da = '0;
    m_ab = '0;
    m_db = '0;

    // Reset overrides vld.
    step(1'b0, 1'b1, 8'h10, 16'hABCD, 8'h00, 16'h0000, 8'h00, 16'h0000);
    // Released, idle: outputs stay zero.
    step(1'b1, 1'b0, 8'h10, 16'hABCD, 8'h00, 16'h0000, 8'h00, 16'h0000);
    step(1'b1, 1'b0, 8'hF3, 16'h5555, 8'h00, 16'h0000, 8'h00, 16'h0000);
    // Port A then port B.
    step(1'b1, 1'b1, 8'h05, 16'h1234, 8'h05, 16'h1234, 8'h00, 16'h0000);
    step(1'b1, 1'b1, 8'hC0, 16'hBEEF, 8'h00, 16'h0000, 8'hC0, 16'hBEEF);
    // Boundary pair, back to back.
    step(1'b1, 1'b1, 8'h3F, 16'h0001, 8'h3F, 16'h0001, 8'h00, 16'h0000);
    step(1'b1, 1'b1, 8'h40, 16'h0002, 8'h00, 16'h0000, 8'h40, 16'h0002);
    // Hold with junk on addr/data.
    step(1'b1, 1'b0, 8'h01, 16'hFFFF, 8'h00, 16'h0000, 8'h40, 16'h0002);
    step(1'b1, 1'b0, 8'h3F, 16'h7A7A, 8'h00, 16'h0000, 8'h40, 16'h0002);
    step(1'b1, 1'b0, 8'hFF, 16'h0F0F, 8'h00, 16'h0000, 8'h40, 16'h0002);
    // Extremes of the address range.
    step(1'b1, 1'b1, 8'h00, 16'hCAFE, 8'h00, 16'hCAFE, 8'h00, 16'h0000);
    step(1'b1, 1'b1, 8'hFF, 16'hD00D, 8'h00, 16'h0000, 8'hFF, 16'hD00D);
    step(1'b1, 1'b1, 8'h3E, 16'h0042, 8'h3E, 16'h0042, 8'h00, 16'h0000);
    // Reset mid-stream after a live transaction.
    step(1'b0, 1'b1, 8'h80, 16'h9999, 8'h00, 16'h0000, 8'h00, 16'h0000);

    // Random stream with a reset pulse partway through.
    for (int i = 0; i < 200; i++) begin
      r = (i == 97 || i == 98) ? 1'b0 : 1'b1;
      v = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      d = 16'($urandom);
      if (!r) step(r, v, a, d, 8'h00, 16'h0000, 8'h00, 16'h0000);
      else if (!v) step(r, v, a, d, m_aa, m_da, m_ab, m_db);
      else if (a <= 8'h3F) step(r, v, a, d, a, d, 8'h00, 16'h0000);
      else step(r, v, a, d, 8'h00, 16'h0000, a, d);
    end

    @(negedge clk);
    vld = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
